// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared RV32I result and CDB broadcast types for the writeback path.
package rv32i_types;

  localparam int CDB_ROB_ID_W = 8;
  localparam int PHYS_REG_W   = 6;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [CDB_ROB_ID_W-1:0] rob_id;
  } rob_t;

  typedef struct packed {
    rob_t  rob;
    rvfi_t rvfi;
  } reservation_entry_t;

  typedef struct packed {
    logic [PHYS_REG_W-1:0] rd;
  } rat_t;

  typedef struct packed {
    logic [4:0] rd_s;
  } inst_t;

  typedef struct packed {
    reservation_entry_t reservation_entry;
    rat_t               rat;
    inst_t              inst;
  } inst_info_t;

  typedef struct packed {
    logic        ready_for_writeback;
    inst_info_t  inst_info;
    logic [31:0] register_value;
  } fu_output_t;

  typedef struct packed {
    logic                    valid;
    logic [CDB_ROB_ID_W-1:0] rob_id;
    logic [PHYS_REG_W-1:0]   rd_phys;
    logic                    rd_we;
    logic [31:0]             value;
    rvfi_t                   rvfi;
  } cdb_t;

endpackage

// File: rtl/cdb_writeback_arbiter_fifo.sv
// Per-FU result buffer: circular FIFO of fu_output_t; flush empties it in one cycle and wins over push/pop.
module fu_wb_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fu_output_t din,
  output logic       full,
  output logic       empty,
  output fu_output_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fu_output_t       mem_q [DEPTH];
  fu_output_t       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin CDB writeback arbiter: per-FU result FIFOs feeding one registered broadcast per cycle.
// Define CDB_BYPASS_EN to let an empty FU's incoming result compete directly for the CDB register.
module cdb_writeback_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  fu_output_t        fu_out [NUM_FU],
  output logic [NUM_FU-1:0] fu_ready,
  output cdb_t              cdb
);

  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] full, empty, push, pop, hs, eligible;
  fu_output_t        head [NUM_FU];
  fu_output_t        sel;
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0]   winner, cand;
  logic              grant, bypass_used;
  cdb_t              cdb_q, cdb_d;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    fu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .flush (flush),
      .din   (fu_out[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
    assign hs[g] = fu_out[g].ready_for_writeback & fu_ready[g];
  end

  assign fu_ready = ~full & {NUM_FU{~flush}};

`ifdef CDB_BYPASS_EN
  assign eligible = ~empty | hs;
`else
  assign eligible = ~empty;
`endif

  // Scan from farthest to nearest so the first eligible index at/after rr_ptr is the last one written.
  always_comb begin
    grant  = 1'b0;
    winner = rr_ptr_q;
    cand   = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      cand = RR_W'((int'(rr_ptr_q) + k) % NUM_FU);
      if (eligible[cand]) begin
        grant  = 1'b1;
        winner = cand;
      end
    end
  end

  // An empty winner can only have qualified through the bypass path.
  assign bypass_used = grant & empty[winner];
  assign sel         = bypass_used ? fu_out[winner] : head[winner];

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]  = !flush && grant && !bypass_used && (winner == RR_W'(i));
      push[i] = hs[i] && !(bypass_used && (winner == RR_W'(i)));
    end
  end

  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (!flush && grant) begin
      cdb_d.valid         = sel.ready_for_writeback;
      cdb_d.rob_id        = sel.inst_info.reservation_entry.rob.rob_id;
      cdb_d.rd_phys       = sel.inst_info.rat.rd;
      cdb_d.rd_we         = |sel.inst_info.inst.rd_s;
      cdb_d.value         = sel.register_value;
      cdb_d.rvfi          = sel.inst_info.reservation_entry.rvfi;
      cdb_d.rvfi.rd_wdata = sel.register_value;
      rr_ptr_d            = (winner == RR_W'(NUM_FU - 1)) ? '0 : winner + RR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb = cdb_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed scenarios plus random traffic against a queue-level reference model.
`timescale 1ns/1ps
module tb_cdb_writeback_arbiter;
  import rv32i_types::*;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  fu_output_t        fu_out [NUM_FU];
  logic [NUM_FU-1:0] fu_ready;
  cdb_t              cdb;

  int errors = 0;
  int checks = 0;

  cdb_writeback_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .fu_out   (fu_out),
    .fu_ready (fu_ready),
    .cdb      (cdb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model: per-FU queues + round-robin pointer ----------------
  fu_output_t        q [NUM_FU][$];
  int                rr;
  cdb_t              exp_cdb;
  logic [NUM_FU-1:0] accepted;

  function automatic cdb_t expect_of(input fu_output_t r);
    cdb_t c;
    c               = '0;
    c.valid         = 1'b1;
    c.rob_id        = r.inst_info.reservation_entry.rob.rob_id;
    c.rd_phys       = r.inst_info.rat.rd;
    c.rd_we         = (r.inst_info.inst.rd_s != 5'd0);
    c.value         = r.register_value;
    c.rvfi          = r.inst_info.reservation_entry.rvfi;
    c.rvfi.rd_wdata = r.register_value;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) q[i].delete();
    rr       = 0;
    exp_cdb  = '0;
    accepted = '0;
  endtask

  task automatic model_step();
    logic [NUM_FU-1:0] take;
    int w;
    bit direct;
    for (int i = 0; i < NUM_FU; i++)
      take[i] = fu_out[i].ready_for_writeback && !flush && (q[i].size() < DEPTH);
    accepted = take;
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) q[i].delete();
      exp_cdb.valid = 1'b0;
      return;
    end
    w = -1;
    for (int k = 0; k < NUM_FU && w < 0; k++) begin
      int i;
      i = (rr + k) % NUM_FU;
      if (q[i].size() > 0 || (BYP && take[i])) w = i;
    end
    direct = 1'b0;
    if (w >= 0) begin
      if (q[w].size() > 0) exp_cdb = expect_of(q[w].pop_front());
      else begin
        exp_cdb = expect_of(fu_out[w]);
        direct  = 1'b1;
      end
      rr = (w + 1) % NUM_FU;
    end else begin
      exp_cdb.valid = 1'b0;
    end
    for (int i = 0; i < NUM_FU; i++)
      if (take[i] && !(direct && i == w)) q[i].push_back(fu_out[i]);
  endtask

  initial begin
    logic [NUM_FU-1:0] exp_rdy;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("cdb", cdb, exp_cdb);
      if (rst_n) begin
        for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = !flush && (q[i].size() < DEPTH);
        chk("fu_ready", fu_ready, exp_rdy);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_mode = 1'b0;
  int prob [NUM_FU];
  int flush_prob = 0;
  int seq [NUM_FU];

  function automatic fu_output_t make_item(input int fu, input int n);
    fu_output_t r;
    r = '0;
    r.ready_for_writeback = 1'b1;
    r.inst_info.reservation_entry.rob.rob_id = 8'(((fu & 3) << 6) | (n & 63));
    r.inst_info.rat.rd = 6'($urandom);
    r.inst_info.inst.rd_s = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
    r.register_value = $urandom;
    r.inst_info.reservation_entry.rvfi.valid    = 1'b1;
    r.inst_info.reservation_entry.rvfi.pc_rdata = $urandom;
    r.inst_info.reservation_entry.rvfi.insn     = $urandom;
    r.inst_info.reservation_entry.rvfi.rd_addr  = r.inst_info.inst.rd_s;
    r.inst_info.reservation_entry.rvfi.rd_wdata = $urandom;
    return r;
  endfunction

  function automatic fu_output_t dir_item(input int rob, input int rds, input logic [31:0] val, input int phys);
    fu_output_t r;
    r = make_item(0, 0);
    r.inst_info.reservation_entry.rob.rob_id = 8'(rob);
    r.inst_info.inst.rd_s = 5'(rds);
    r.inst_info.rat.rd = 6'(phys);
    r.register_value = val;
    return r;
  endfunction

  // Random FU drivers hold an offer until the model saw it accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_mode) begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (!fu_out[i].ready_for_writeback || accepted[i]) begin
            if ($urandom_range(99) < prob[i]) begin
              fu_out[i] = make_item(i, seq[i]);
              seq[i]++;
            end else fu_out[i] = '0;
          end
        end
        flush = ($urandom_range(99) < flush_prob);
      end
    end
  end

  task automatic send_and_wait(input int fu, input fu_output_t item, output int lat, output cdb_t snap);
    lat  = 0;
    snap = '0;
    @(negedge clk);
    fu_out[fu] = item;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) fu_out[fu] = '0;
      if (cdb.valid && lat == 0) begin
        lat  = c;
        snap = cdb;
      end
    end
  endtask

  task automatic offer_all(input int base, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) fu_out[i] = dir_item(base + i, 1 + i, 32'h1000 + base + i, 10 + i);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_FU; i++) fu_out[i] = '0;
  endtask

  initial begin
    int   lat;
    cdb_t snap;
    logic [7:0] order [$];
    int   gap;
    bit   saw_bp;

    clear_all();
    for (int i = 0; i < NUM_FU; i++) begin
      prob[i] = 0;
      seq[i]  = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", fu_ready, {NUM_FU{1'b1}});
    chk("cdb_valid_after_reset", cdb.valid, 1'b0);

    // single FU latency and field mapping
    send_and_wait(0, dir_item(5, 3, 32'hDEADBEEF, 9), lat, snap);
    chk("single_latency", lat, LAT);
    chk("single_rob_id", snap.rob_id, 8'd5);
    chk("single_value", snap.value, 32'hDEADBEEF);
    chk("single_rd_we", snap.rd_we, 1'b1);
    chk("single_rd_phys", snap.rd_phys, 6'd9);
    chk("single_rvfi_wdata", snap.rvfi.rd_wdata, 32'hDEADBEEF);

    // move rr_ptr to 2, then two rounds of four-way contention
    send_and_wait(1, dir_item(1, 1, 32'h11, 1), lat, snap);
    for (int round = 0; round < 2; round++) begin
      order.delete();
      offer_all(8'h20 + 16 * round, NUM_FU);
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        #1;
        if (c == 1) clear_all();
        if (cdb.valid) order.push_back(cdb.rob_id);
      end
      chk("contend_count", order.size(), NUM_FU);
      for (int k = 0; k < NUM_FU && k < order.size(); k++)
        chk("contend_order", order[k], 8'(8'h20 + 16 * round + ((2 + k) % NUM_FU)));
    end

    // rd_s == 0 still broadcasts
    send_and_wait(2, dir_item(7, 0, 32'h77, 4), lat, snap);
    chk("rd0_valid", snap.valid, 1'b1);
    chk("rd0_rob_id", snap.rob_id, 8'd7);
    chk("rd0_rd_we", snap.rd_we, 1'b0);

    // flush with three buffered results and a live broadcast
    offer_all(8'h40, NUM_FU);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) clear_all();
    end
    chk("pre_flush_valid", cdb.valid, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    fu_out[0] = dir_item(8'h55, 2, 32'h55, 5);
    #1;
    chk("flush_ready_low", fu_ready, {NUM_FU{1'b0}});
    @(posedge clk);
    #1;
    chk("flush_cdb_valid", cdb.valid, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    clear_all();
    #1;
    chk("post_flush_ready", fu_ready, {NUM_FU{1'b1}});
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("post_flush_quiet", cdb.valid, 1'b0);
    end

    // async reset mid-burst
    offer_all(8'h60, 3);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) clear_all();
    end
    chk("pre_reset_valid", cdb.valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_cdb_now", cdb.valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_ready", fu_ready, {NUM_FU{1'b1}});
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("reset_no_stale", cdb.valid, 1'b0);
    end

    // backpressure: FU0 and FU1 stream every cycle
    @(negedge clk);
    prob[0] = 100;
    prob[1] = 100;
    flush_prob = 0;
    rand_mode = 1'b1;
    gap = 0;
    saw_bp = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      if (!fu_ready[1]) saw_bp = 1'b1;
      if (cdb.valid) begin
        if (cdb.rob_id[7:6] == 2'd1) begin
          chk("fu1_starve_gap", gap <= NUM_FU, 1'b1);
          gap = 0;
        end else gap++;
      end
    end
    chk("fu1_backpressure_seen", saw_bp, 1'b1);

    // mixed random traffic with occasional flushes
    for (int i = 0; i < NUM_FU; i++) prob[i] = 30 + 15 * i;
    flush_prob = 3;
    repeat (500) @(negedge clk);

    rand_mode = 1'b0;
    flush = 1'b0;
    clear_all();
    repeat (12) @(negedge clk);
    chk("drain_idle", cdb.valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
